// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: splits each instruction into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK phases and gates datapath write strobes
// Ports: clock, reset_n (async, active-low); run, halt, ramconfig, regbankconfig, regsource (instruction decode);
//        imem_req/imem_ready and dmem_req/dmem_ready (memory handshakes); ir_load, dmem_we, regbank_we, pc_enable (strobes);
//        state, busy, fault (status); retired, cycles (counters)
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic                 halt,
   input  logic                 ramconfig,
   input  logic                 regbankconfig,
   input  logic [1:0]           regsource,
   input  logic                 imem_ready,
   input  logic                 dmem_ready,
   output logic                 imem_req,
   output logic                 ir_load,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic                 regbank_we,
   output logic                 pc_enable,
   output logic [2:0]           state,
   output logic                 busy,
   output logic                 fault,
   output logic [CNT_WIDTH-1:0] retired,
   output logic [CNT_WIDTH-1:0] cycles
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED, FAULT} state_t;
   state_t               state_q, state_d;
   logic [WW-1:0]        wait_q, wait_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d, cycles_q, cycles_d;
   logic                 retire, timeout;
   always_comb begin
      state_d    = state_q;
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      regbank_we = 1'b0;
      retire     = 1'b0;
      timeout    = wait_q == WW'(MEM_TIMEOUT - 1);
      case (state_q)
         IDLE:      state_d = run ? FETCH : IDLE;
         FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ready;
            state_d  = imem_ready ? DECODE : timeout ? FAULT : FETCH;
         end
         DECODE:    state_d = halt ? HALTED : EXECUTE;
         EXECUTE: begin
            if (ramconfig || regsource == 2'b01) state_d = MEMORY;
            else if (regbankconfig) state_d = WRITEBACK;
            else retire = 1'b1;
         end
         MEMORY: begin
            dmem_req = 1'b1;
            dmem_we  = ramconfig;
            if (dmem_ready) begin
               if (regbankconfig) state_d = WRITEBACK;
               else retire = 1'b1;
            end else if (timeout) state_d = FAULT;
         end
         WRITEBACK: begin
            regbank_we = 1'b1;
            retire     = 1'b1;
         end
         default: ;
      endcase
      if (retire) state_d = run ? FETCH : IDLE;
      pc_enable = retire;
      // the wait counter only advances while parked in a handshake state; any entry clears it
      wait_d    = (state_d == state_q && (state_q == FETCH || state_q == MEMORY)) ? wait_q + WW'(1) : '0;
      busy      = state_q != IDLE && state_q != HALTED && state_q != FAULT;
      fault     = state_q == FAULT;
      retired_d = retired_q + CNT_WIDTH'(retire);
      cycles_d  = cycles_q + CNT_WIDTH'(busy);
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         retired_q <= '0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         cycles_q  <= cycles_d;
      end
   end
   assign state   = state_q;
   assign retired = retired_q;
   assign cycles  = cycles_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: table-driven and scoreboarded check of the multi-cycle sequencer
module tb_multicycle_sequencer;
   logic        clock = 1'b0, reset_n = 1'b0;
   logic        run = 1'b0, halt = 1'b0, ramconfig = 1'b0, regbankconfig = 1'b0;
   logic [1:0]  regsource = 2'b00;
   logic        imem_ready = 1'b0, dmem_ready = 1'b0;
   logic        imem_req, ir_load, dmem_req, dmem_we, regbank_we, pc_enable, busy, fault;
   logic [2:0]  state;
   logic [31:0] retired, cycles;
   int          total = 0, bad = 0;

   // in  = {run, halt, ramconfig, regbankconfig, regsource[1:0], imem_ready, dmem_ready}
   // exp = {state[2:0], imem_req, ir_load, dmem_req, dmem_we, regbank_we, pc_enable}
   typedef struct {
      string      name;
      logic [7:0] in;
      logic [8:0] exp;
   } vec_t;
   vec_t        tbl[$];
   logic [10:0] sb[$];

   multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_WIDTH(32)) dut (
      .clock(clock), .reset_n(reset_n), .run(run), .halt(halt), .ramconfig(ramconfig),
      .regbankconfig(regbankconfig), .regsource(regsource), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .regbank_we(regbank_we), .pc_enable(pc_enable), .state(state),
      .busy(busy), .fault(fault), .retired(retired), .cycles(cycles)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input string n, input logic [7:0] i, input logic [8:0] e);
      vec_t v;
      v.name = n;
      v.in   = i;
      v.exp  = e;
      return v;
   endfunction

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", n, act, exp, $time);
      end
   endtask

   // drive one cycle of stimulus, queue its expectation, compare mid-cycle, then advance past the edge
   task automatic apply(input vec_t v);
      logic [10:0] e;
      logic [2:0]  st;
      {run, halt, ramconfig, regbankconfig, regsource, imem_ready, dmem_ready} = v.in;
      st = v.exp[8:6];
      sb.push_back({v.exp, st >= 3'd1 && st <= 3'd5, st == 3'd7});
      #3;
      e = sb.pop_front();
      check(v.name, {21'd0, state, imem_req, ir_load, dmem_req, dmem_we, regbank_we, pc_enable, busy, fault}, {21'd0, e});
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      // ALU op
      tbl.push_back(mk("alu_idle",  8'b1001_0010, 9'b000_000000));
      tbl.push_back(mk("alu_fetch", 8'b1001_0010, 9'b001_110000));
      tbl.push_back(mk("alu_dec",   8'b1001_0010, 9'b010_000000));
      tbl.push_back(mk("alu_exe",   8'b1001_0010, 9'b011_000000));
      tbl.push_back(mk("alu_wb",    8'b1001_0010, 9'b101_000011));
      // store with two wait cycles
      tbl.push_back(mk("st_fetch",  8'b1010_0010, 9'b001_110000));
      tbl.push_back(mk("st_dec",    8'b1010_0010, 9'b010_000000));
      tbl.push_back(mk("st_exe",    8'b1010_0010, 9'b011_000000));
      tbl.push_back(mk("st_mem0",   8'b1010_0010, 9'b100_001100));
      tbl.push_back(mk("st_mem1",   8'b1010_0010, 9'b100_001100));
      tbl.push_back(mk("st_mem2",   8'b1010_0011, 9'b100_001101));
      // load with immediate ready
      tbl.push_back(mk("ld_fetch",  8'b1001_0111, 9'b001_110000));
      tbl.push_back(mk("ld_dec",    8'b1001_0111, 9'b010_000000));
      tbl.push_back(mk("ld_exe",    8'b1001_0111, 9'b011_000000));
      tbl.push_back(mk("ld_mem",    8'b1001_0111, 9'b100_001000));
      tbl.push_back(mk("ld_wb",     8'b1001_0111, 9'b101_000011));
      // plain op retiring in EXECUTE, one fetch wait, run dropped mid-instruction
      tbl.push_back(mk("nop_wait",  8'b1000_0000, 9'b001_100000));
      tbl.push_back(mk("nop_fetch", 8'b1000_0010, 9'b001_110000));
      tbl.push_back(mk("nop_dec",   8'b0000_0010, 9'b010_000000));
      tbl.push_back(mk("nop_exe",   8'b0000_0010, 9'b011_000001));
      tbl.push_back(mk("idle0",     8'b0000_0010, 9'b000_000000));
      tbl.push_back(mk("idle1",     8'b0000_0010, 9'b000_000000));

      @(posedge clock);
      #2;
      check("rst_out", {23'd0, state, imem_req, ir_load, dmem_req, dmem_we, regbank_we, pc_enable, busy, fault}, 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_cycles", cycles, 32'd0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
      check("chain_retired", retired, 32'd4);
      check("chain_cycles", cycles, 32'd19);

      // fetch timeout: 15 request cycles then FAULT
      do_reset();
      apply(mk("to_idle", 8'b1000_0000, 9'b000_000000));
      for (int i = 0; i < 15; i++) apply(mk("to_fetch", 8'b1000_0000, 9'b001_100000));
      apply(mk("to_fault0", 8'b1000_0000, 9'b111_000000));
      apply(mk("to_fault1", 8'b0000_0011, 9'b111_000000));
      check("to_cycles", cycles, 32'd15);

      // ready on the 15th cycle wins, then halt at DECODE
      do_reset();
      apply(mk("bd_idle", 8'b1000_0000, 9'b000_000000));
      for (int i = 0; i < 14; i++) apply(mk("bd_fetch", 8'b1000_0000, 9'b001_100000));
      apply(mk("bd_ready", 8'b1000_0010, 9'b001_110000));
      apply(mk("bd_dec",   8'b1100_0010, 9'b010_000000));
      apply(mk("hlt0",     8'b1100_0010, 9'b110_000000));
      apply(mk("hlt1",     8'b0000_0011, 9'b110_000000));
      apply(mk("hlt2",     8'b1001_0011, 9'b110_000000));
      check("hlt_retired", retired, 32'd0);
      check("hlt_cycles", cycles, 32'd16);

      // reset in the middle of a store's MEMORY phase
      do_reset();
      apply(mk("rm_idle",  8'b1000_0010, 9'b000_000000));
      apply(mk("rm_fetch", 8'b1000_0010, 9'b001_110000));
      apply(mk("rm_dec",   8'b1000_0010, 9'b010_000000));
      apply(mk("rm_exe",   8'b1000_0010, 9'b011_000001));
      apply(mk("rm_fetch2", 8'b1010_0010, 9'b001_110000));
      apply(mk("rm_dec2",  8'b1010_0010, 9'b010_000000));
      apply(mk("rm_exe2",  8'b1010_0010, 9'b011_000000));
      {run, halt, ramconfig, regbankconfig, regsource, imem_ready, dmem_ready} = 8'b1010_0010;
      #2;
      check("rm_mem", {27'd0, state, dmem_req, dmem_we}, {27'd0, 3'd4, 2'b11});
      check("rm_pre_retired", retired, 32'd1);
      reset_n = 1'b0;
      #1;
      check("rm_rst", {27'd0, state, dmem_req, dmem_we}, 32'd0);
      check("rm_rst_retired", retired, 32'd0);
      check("rm_rst_cycles", cycles, 32'd0);
      #1;
      reset_n = 1'b1;
      #1;
      check("rm_rel_state", {29'd0, state}, 32'd0);
      @(posedge clock);
      #1;
      check("rm_rel_fetch", {29'd0, state}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the CPU datapath: program counter, register bank, ALU, program memory and data RAM.
- Replaces the free-running single-cycle clocking. It splits each instruction into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK phases and gates every state-changing write strobe.
- Supports variable-latency instruction and data memories through req/ready handshakes with a timeout.
- Sits between control_unit (static per-instruction decode) and the storage elements.

Parameters:
- MEM_TIMEOUT, 15: max consecutive not-ready cycles tolerated in FETCH or MEMORY before FAULT.
- CNT_WIDTH, 32: width of the retired and cycles counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; enables starting or continuing instruction execution.
- halt  in  1  decoded halt instruction (from control_unit).
- ramconfig  in  1  instruction writes RAM (store).
- regbankconfig  in  1  instruction writes register bank.
- regsource  in  2  register bank source: 00 alu, 01 ram (load), 10 pc.
- imem_ready  in  1  instruction memory has valid data.
- dmem_ready  in  1  data RAM access complete.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  capture instruction register.
- dmem_req  out  1  data RAM access request.
- dmem_we  out  1  data RAM write enable (gated ramconfig).
- regbank_we  out  1  register bank write enable (gated regbankconfig).
- pc_enable  out  1  program counter update strobe.
- state  out  3  current state encoding.
- busy  out  1  high in states 1..5.
- fault  out  1  high in FAULT.
- retired  out  CNT_WIDTH  instructions retired.
- cycles  out  CNT_WIDTH  clock cycles spent in states 1..5.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6, FAULT=7.
- Reset (async, reset_n low): state=IDLE. All strobes, busy and fault are 0. retired=0, cycles=0, wait counter=0. Reset takes effect immediately, including mid-MEMORY; there is no partial write completion.
- IDLE: if run, go to FETCH next edge; else stay.
- FETCH: imem_req=1. If imem_ready: ir_load=1 (same cycle, combinational from state & ready), then go to DECODE.
- DECODE: exactly 1 cycle. If halt, go to HALTED (no retire, no pc_enable); else go to EXECUTE.
- EXECUTE: exactly 1 cycle, with the following priority:
  - ramconfig=1 or regsource=01: go to MEMORY.
  - else regbankconfig=1: go to WRITEBACK.
  - else retire in this cycle.
- MEMORY: dmem_req=1 and dmem_we=ramconfig, both held until dmem_ready. On the ready cycle: if regbankconfig, go to WRITEBACK; else retire in this cycle.
- WRITEBACK: exactly 1 cycle. regbank_we=1 and pc_enable=1; retire.
- Retire cycle:
  - pc_enable=1 for exactly one cycle; retired increments by 1 at the closing edge, wrapping modulo 2^CNT_WIDTH.
  - Next state is FETCH if run=1, else IDLE.
  - Dropping run mid-instruction always completes the current instruction.
- HALTED and FAULT are absorbing; only reset exits them.
- Wait counter:
  - Cleared on entry to FETCH/MEMORY; increments each cycle the ready input is low.
  - If ready is low while the counter equals MEM_TIMEOUT-1, the next state is FAULT and the request drops.
  - Ready on that same cycle wins over timeout.
- cycles increments every cycle while state is 1..5 and wraps; it is frozen in IDLE/HALTED/FAULT.
- Strobes (ir_load, dmem_we, regbank_we, pc_enable) are never asserted outside their states. dmem_we=0 whenever dmem_req=0.
- Control inputs are sampled only in EXECUTE/MEMORY/WRITEBACK. Stability during that window is provided by the held instruction register.

Test Plan:
- ALU op (regbankconfig=1, ramconfig=0, regsource=00), run=1, imem_ready=1 -> state sequence 1,2,3,5,1; ir_load=1 in cycle 1; regbank_we=pc_enable=1 only in cycle 4; retired=1, cycles=4 after 4 edges.
- Store (ramconfig=1, regbankconfig=0), dmem_ready low 2 cycles then high -> dmem_req=dmem_we=1 for 3 cycles; pc_enable=1 on the ready cycle only; regbank_we stays 0; retired=1.
- Load (regsource=01, regbankconfig=1), dmem_ready immediate -> states 1,2,3,4,5; dmem_we=0 throughout; regbank_we pulses once in WRITEBACK.
- imem_ready held 0 with MEM_TIMEOUT=15 -> imem_req high for 15 cycles, then state=7, fault=1, imem_req=0. Repeat with ready asserted on the 15th cycle -> DECODE, no fault.
- halt=1 at DECODE -> state=6, pc_enable never pulses, retired unchanged; run toggling has no effect.
- reset_n low mid-MEMORY (dmem_we=1) -> dmem_we, dmem_req and state go to 0 before the next edge; retired=0; run=1 after release -> FETCH one edge later.
